// File: rtl/amm_arb_pkg.sv
// Shared types and helpers for the Avalon-MM round-robin arbiter.
package amm_arb_pkg;

  // Command-side FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WR_BURST = 2'd2
  } arb_state_t;

  // Widest requester id / read length an owner entry can describe.
  localparam int unsigned ID_MAX_W  = 8;
  localparam int unsigned LEN_MAX_W = 16;

  // Decoded owner FIFO entry: who issued the read and how many beats it returns.
  typedef struct packed {
    logic [ID_MAX_W-1:0]  id;
    logic [LEN_MAX_W-1:0] len;
  } owner_entry_t;

  // Requester id width; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_owner_fifo.sv
// Show-ahead single-clock FIFO recording the owner of each outstanding read.
module rd_owner_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/amm_arbiter.sv
// Round-robin Avalon-MM arbiter: one granted requester drives the memory port,
// write bursts keep the grant, read data is steered back via the owner FIFO.
module amm_arbiter
  import amm_arb_pkg::*;
#(
  parameter int unsigned MASTERS_CNT   = 2,
  parameter int unsigned ADDR_W        = 31,
  parameter int unsigned DATA_W        = 128,
  parameter int unsigned BURST_W       = 11,
  parameter int unsigned RD_FIFO_DEPTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [MASTERS_CNT*ADDR_W-1:0]   i_s_address,
  input  logic [MASTERS_CNT-1:0]          i_s_read,
  input  logic [MASTERS_CNT-1:0]          i_s_write,
  input  logic [MASTERS_CNT*DATA_W/8-1:0] i_s_byteenable,
  input  logic [MASTERS_CNT*BURST_W-1:0]  i_s_burstcount,
  input  logic [MASTERS_CNT*DATA_W-1:0]   i_s_writedata,
  output logic [MASTERS_CNT-1:0]          o_s_waitrequest,
  output logic [MASTERS_CNT-1:0]          o_s_readdatavalid,
  output logic [DATA_W-1:0]               o_s_readdata,
  output logic [ADDR_W-1:0]               o_m_address,
  output logic                            o_m_read,
  output logic                            o_m_write,
  output logic [DATA_W/8-1:0]             o_m_byteenable,
  output logic [BURST_W-1:0]              o_m_burstcount,
  output logic [DATA_W-1:0]               o_m_writedata,
  input  logic                            i_m_waitrequest,
  input  logic                            i_m_readdatavalid,
  input  logic [DATA_W-1:0]               i_m_readdata
);

  localparam int unsigned IDW   = id_w(MASTERS_CNT);
  localparam int unsigned BEW   = DATA_W / 8;
  localparam int unsigned ENT_W = IDW + BURST_W;

  arb_state_t         r_state, w_state_next;
  logic [IDW-1:0]     r_grant, w_grant_next;
  logic [IDW-1:0]     r_last_grant, w_last_grant_next;
  logic [BURST_W-1:0] r_beats_left, w_beats_left_next;
  logic [BURST_W-1:0] r_rd_beat;

  logic [ADDR_W-1:0]  w_s_addr [MASTERS_CNT];
  logic [BEW-1:0]     w_s_be   [MASTERS_CNT];
  logic [BURST_W-1:0] w_s_bc   [MASTERS_CNT];
  logic [DATA_W-1:0]  w_s_wd   [MASTERS_CNT];

  logic               w_g_read, w_g_write;
  logic [BURST_W-1:0] w_g_bc_eff;
  logic [MASTERS_CNT-1:0] w_elig;
  logic               w_pick_valid;
  logic [IDW-1:0]     w_pick;
  logic               w_wr_acc, w_rd_acc;

  logic               w_fifo_full, w_fifo_empty, w_push;
  logic [ENT_W-1:0]   w_fifo_rdata;
  owner_entry_t       w_rd_head;
  logic               w_rd_valid, w_rd_last;

  for (genvar gi = 0; gi < MASTERS_CNT; gi++) begin : g_unpack
    assign w_s_addr[gi] = i_s_address[gi*ADDR_W +: ADDR_W];
    assign w_s_be[gi]   = i_s_byteenable[gi*BEW +: BEW];
    assign w_s_bc[gi]   = i_s_burstcount[gi*BURST_W +: BURST_W];
    assign w_s_wd[gi]   = i_s_writedata[gi*DATA_W +: DATA_W];
  end

  // Granted requester's command; qualified by o_m_read/o_m_write.
  assign w_g_read       = i_s_read[r_grant];
  assign w_g_write      = i_s_write[r_grant];
  assign w_g_bc_eff     = (w_s_bc[r_grant] == '0) ? BURST_W'(1) : w_s_bc[r_grant];
  assign o_m_address    = w_s_addr[r_grant];
  assign o_m_byteenable = w_s_be[r_grant];
  assign o_m_burstcount = w_s_bc[r_grant];
  assign o_m_writedata  = w_s_wd[r_grant];

  assign w_wr_acc = o_m_write & ~i_m_waitrequest;
  assign w_rd_acc = o_m_read & ~i_m_waitrequest;

  // Reads are only eligible while the owner FIFO can take another entry.
  assign w_elig = i_s_write | (i_s_read & {MASTERS_CNT{~w_fifo_full}});

  // Round-robin pick: scan from farthest to nearest after last_grant so the nearest wins.
  always_comb begin
    int v_idx;
    v_idx        = 0;
    w_pick_valid = 1'b0;
    w_pick       = '0;
    for (int k = int'(MASTERS_CNT); k > 0; k--) begin
      v_idx = (int'(r_last_grant) + k) % int'(MASTERS_CNT);
      if (w_elig[IDW'(v_idx)]) begin
        w_pick_valid = 1'b1;
        w_pick       = IDW'(v_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Grant and write-burst bookkeeping; last_grant resets so requester 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant      <= '0;
      r_last_grant <= IDW'(MASTERS_CNT - 1);
      r_beats_left <= '0;
    end else begin
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_beats_left <= w_beats_left_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_beats_left_next = r_beats_left;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_next      = CMD;
          w_grant_next      = w_pick;
          w_last_grant_next = w_pick;
        end
      end
      CMD: begin
        if (w_wr_acc) begin
          if (w_g_bc_eff == BURST_W'(1)) begin
            w_state_next = IDLE;
          end else begin
            w_beats_left_next = w_g_bc_eff - 1'b1;
            w_state_next      = WR_BURST;
          end
        end else if (w_rd_acc) begin
          w_state_next = IDLE;
        end
      end
      WR_BURST: begin
        if (w_wr_acc) begin
          w_beats_left_next = r_beats_left - 1'b1;
          if (r_beats_left == BURST_W'(1)) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Command-side outputs; only the granted requester sees the memory's backpressure.
  always_comb begin
    o_m_read        = 1'b0;
    o_m_write       = 1'b0;
    o_s_waitrequest = '1;
    case (r_state)
      CMD: begin
        o_m_write                = w_g_write;
        o_m_read                 = w_g_read & ~w_g_write;
        o_s_waitrequest[r_grant] = i_m_waitrequest;
      end
      WR_BURST: begin
        o_m_write                = w_g_write;
        o_s_waitrequest[r_grant] = i_m_waitrequest;
      end
      default: ;
    endcase
  end

  assign w_push = (r_state == CMD) & w_rd_acc;

  rd_owner_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata ({r_grant, w_g_bc_eff}),
    .i_pop   (w_rd_last),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_rd_head.id  = ID_MAX_W'(w_fifo_rdata[ENT_W-1:BURST_W]);
  assign w_rd_head.len = LEN_MAX_W'(w_fifo_rdata[BURST_W-1:0]);

  // Stray data with nothing outstanding is dropped.
  assign w_rd_valid   = i_m_readdatavalid & ~w_fifo_empty;
  assign w_rd_last    = w_rd_valid & ((LEN_MAX_W'(r_rd_beat) + LEN_MAX_W'(1)) == w_rd_head.len);
  assign o_s_readdata = i_m_readdata;

  // Steer the read strobe to the owner of the oldest outstanding read.
  always_comb begin
    o_s_readdatavalid = '0;
    for (int i = 0; i < int'(MASTERS_CNT); i++) begin
      o_s_readdatavalid[i] = w_rd_valid & (w_rd_head.id == ID_MAX_W'(i));
    end
  end

  // Beats returned so far for the head entry.
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_rd_beat <= '0;
    else if (w_rd_last)  r_rd_beat <= '0;
    else if (w_rd_valid) r_rd_beat <= r_rd_beat + 1'b1;
  end

  // Data returned with no read outstanding is a memory-side protocol violation.
  a_no_orphan_data : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_m_readdatavalid && w_fifo_empty))
    else $error("amm_arbiter: readdatavalid with no outstanding read");

endmodule

// File: tb/tb_amm_arbiter.sv
// Directed bench for amm_arbiter: fairness, burst lock, read routing, FIFO full,
// backpressure and reset mid-burst.
module tb_amm_arbiter;

  logic         clk;
  logic         rst;
  logic [61:0]  s_address;
  logic [1:0]   s_read;
  logic [1:0]   s_write;
  logic [31:0]  s_byteenable;
  logic [21:0]  s_burstcount;
  logic [255:0] s_writedata;
  logic [1:0]   s_waitrequest;
  logic [1:0]   s_readdatavalid;
  logic [127:0] s_readdata;
  logic [30:0]  m_address;
  logic         m_read;
  logic         m_write;
  logic [15:0]  m_byteenable;
  logic [10:0]  m_burstcount;
  logic [127:0] m_writedata;
  logic         m_waitrequest;
  logic         m_readdatavalid;
  logic [127:0] m_readdata;

  int n_cmp  = 0;
  int n_fail = 0;

  amm_arbiter dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_s_address       (s_address),
    .i_s_read          (s_read),
    .i_s_write         (s_write),
    .i_s_byteenable    (s_byteenable),
    .i_s_burstcount    (s_burstcount),
    .i_s_writedata     (s_writedata),
    .o_s_waitrequest   (s_waitrequest),
    .o_s_readdatavalid (s_readdatavalid),
    .o_s_readdata      (s_readdata),
    .o_m_address       (m_address),
    .o_m_read          (m_read),
    .o_m_write         (m_write),
    .o_m_byteenable    (m_byteenable),
    .o_m_burstcount    (m_burstcount),
    .o_m_writedata     (m_writedata),
    .i_m_waitrequest   (m_waitrequest),
    .i_m_readdatavalid (m_readdatavalid),
    .i_m_readdata      (m_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst             = 1'b1;
    s_address       = {31'h200, 31'h100};
    s_read          = 2'b00;
    s_write         = 2'b00;
    s_byteenable    = '1;
    s_burstcount    = {11'd1, 11'd1};
    s_writedata     = {128'hB1, 128'hA0};
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    step();
    step();

    // Reset state.
    check("rst_waitreq", s_waitrequest, 2'b11);
    check("rst_m_write", m_write, 1'b0);
    check("rst_m_read", m_read, 1'b0);
    check("rst_rdv", s_readdatavalid, 2'b00);

    // Fairness: continuous single writes from both requesters alternate 0,1,0.
    rst     = 1'b0;
    s_write = 2'b11;
    #1;
    check("rr_idle_write", m_write, 1'b0);
    step();
    check("rr_g0_write", m_write, 1'b1);
    check("rr_g0_addr", m_address, 31'h100);
    check("rr_g0_wdata", m_writedata, 128'hA0);
    check("rr_g0_waitreq", s_waitrequest, 2'b10);
    step();
    check("rr_bubble", m_write, 1'b0);
    check("rr_bubble_waitreq", s_waitrequest, 2'b11);
    step();
    check("rr_g1_addr", m_address, 31'h200);
    check("rr_g1_waitreq", s_waitrequest, 2'b01);
    step();
    check("rr_bubble2", m_write, 1'b0);
    step();
    check("rr_g0_again", m_address, 31'h100);
    check("rr_g0_again_wr", m_write, 1'b1);
    step();
    s_write = 2'b00;

    // Burst lock: requester 0 bursts 4 beats, requester 1 read waits it out.
    s_write[0]         = 1'b1;
    s_burstcount[10:0] = 11'd4;
    step();
    check("bl_beat1_bc", m_burstcount, 11'd4);
    s_read[1] = 1'b1;
    #1;
    check("bl_beat1_waitreq", s_waitrequest, 2'b10);
    step();
    s_writedata[127:0] = 128'hA1;
    #1;
    check("bl_beat2_write", m_write, 1'b1);
    check("bl_beat2_wdata", m_writedata, 128'hA1);
    check("bl_beat2_waitreq", s_waitrequest, 2'b10);
    step();
    s_write[0] = 1'b0;
    #1;
    check("bl_gap_write", m_write, 1'b0);
    check("bl_gap_read", m_read, 1'b0);
    check("bl_gap_waitreq", s_waitrequest, 2'b10);
    step();
    s_write[0] = 1'b1;
    step();
    check("bl_beat4_write", m_write, 1'b1);
    check("bl_beat4_waitreq", s_waitrequest, 2'b10);
    step();
    s_write[0] = 1'b0;
    #1;
    check("bl_after_idle", s_waitrequest, 2'b11);
    check("bl_after_read", m_read, 1'b0);
    step();
    check("bl_rd_granted", m_read, 1'b1);
    check("bl_rd_addr", m_address, 31'h200);
    check("bl_rd_waitreq", s_waitrequest, 2'b01);
    step();
    s_read          = 2'b00;
    m_readdatavalid = 1'b1;
    m_readdata      = 128'hD00D;
    #1;
    check("bl_rd_rdv", s_readdatavalid, 2'b10);
    check("bl_rd_data", s_readdata, 128'hD00D);
    step();
    m_readdatavalid = 1'b0;

    // Read routing: req0 reads 3 beats, req1 reads 2; 5 beats come back-to-back.
    s_read                = 2'b11;
    s_burstcount          = {11'd2, 11'd3};
    step();
    check("rt_g0_read", m_read, 1'b1);
    check("rt_g0_bc", m_burstcount, 11'd3);
    step();
    s_read[0] = 1'b0;
    step();
    check("rt_g1_read", m_read, 1'b1);
    check("rt_g1_bc", m_burstcount, 11'd2);
    step();
    s_read = 2'b00;
    for (int k = 0; k < 5; k++) begin
      m_readdatavalid = 1'b1;
      m_readdata      = 128'h50 + 128'(k);
      #1;
      check("rt_rdv", s_readdatavalid, (k < 3) ? 2'b01 : 2'b10);
      check("rt_data", s_readdata, 128'h50 + 128'(k));
      step();
    end
    m_readdatavalid = 1'b0;
    #1;
    check("rt_fifo_empty", dut.u_fifo.o_empty, 1'b1);

    // FIFO full: 8 single reads from req0, then req1 read is held.
    s_burstcount = {11'd1, 11'd1};
    s_read       = 2'b01;
    for (int k = 0; k < 8; k++) begin
      step();
      step();
    end
    s_read = 2'b10;
    #1;
    check("ff_full", dut.u_fifo.o_full, 1'b1);
    check("ff_held_waitreq", s_waitrequest, 2'b11);
    step();
    check("ff_held_read", m_read, 1'b0);
    check("ff_held_waitreq2", s_waitrequest, 2'b11);
    m_readdatavalid = 1'b1;
    #1;
    check("ff_ret_rdv", s_readdatavalid, 2'b01);
    step();
    m_readdatavalid = 1'b0;
    #1;
    check("ff_pop_idle", m_read, 1'b0);
    step();
    check("ff_grant_read", m_read, 1'b1);
    check("ff_grant_addr", m_address, 31'h200);
    check("ff_grant_waitreq", s_waitrequest, 2'b01);
    step();
    s_read = 2'b00;
    for (int k = 0; k < 8; k++) begin
      m_readdatavalid = 1'b1;
      #1;
      check("ff_drain_rdv", s_readdatavalid, (k < 7) ? 2'b01 : 2'b10);
      step();
    end
    m_readdatavalid = 1'b0;
    #1;
    check("ff_drain_empty", dut.u_fifo.o_empty, 1'b1);

    // Backpressure: memory stalls 5 cycles during CMD.
    m_waitrequest = 1'b1;
    s_write       = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_waitreq", s_waitrequest, 2'b11);
      check("bp_write", m_write, 1'b1);
      check("bp_addr", m_address, 31'h200);
      check("bp_wdata", m_writedata, 128'hB1);
      step();
    end
    m_waitrequest = 1'b0;
    #1;
    check("bp_release_waitreq", s_waitrequest, 2'b01);
    step();
    s_write = 2'b00;
    #1;
    check("bp_done_write", m_write, 1'b0);

    // Reset mid-burst at beat 2 of an 8-beat write.
    s_write[0]         = 1'b1;
    s_burstcount[10:0] = 11'd8;
    step();
    check("rb_beat1", m_write, 1'b1);
    step();
    rst     = 1'b1;
    s_write = 2'b11;
    #1;
    check("rb_beat2", m_write, 1'b1);
    step();
    check("rb_after_write", m_write, 1'b0);
    check("rb_after_waitreq", s_waitrequest, 2'b11);
    rst                = 1'b0;
    s_burstcount[10:0] = 11'd1;
    step();
    check("rb_first_grant", m_address, 31'h100);
    check("rb_first_waitreq", s_waitrequest, 2'b10);
    step();
    s_write = 2'b00;
    #1;
    check("rb_idle", m_write, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/amm_arbiter.md
# amm_arbiter

Round-robin arbiter that shares one Avalon-MM master port among `MASTERS_CNT` requesters (checker write/read generators, CSR debug port) in the memory checker. It serialises commands, holds the grant for the full duration of a write burst, and routes read responses back to the issuing requester through an in-order owner FIFO. It sits between the requester-side `amm_if` slave ports and the single `amm_if` master port toward the memory controller.

## Interface
Parameters:
- `MASTERS_CNT`, 2: number of requesters, at least 2.
- `ADDR_W`, 31: address width.
- `DATA_W`, 128: data width; byteenable width is `DATA_W/8`.
- `BURST_W`, 11: burstcount width.
- `RD_FIFO_DEPTH`, 8: maximum outstanding read commands; power of 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `s_address` in `MASTERS_CNT*ADDR_W`: requester addresses, packed; requester i occupies slice i.
- `s_read`, `s_write` in `MASTERS_CNT`: per-requester commands.
- `s_byteenable` in `MASTERS_CNT*DATA_W/8`: per-requester byte enables.
- `s_burstcount` in `MASTERS_CNT*BURST_W`: per-requester burst lengths.
- `s_writedata` in `MASTERS_CNT*DATA_W`: per-requester write data.
- `s_waitrequest` out `MASTERS_CNT`: per-requester backpressure.
- `s_readdatavalid` out `MASTERS_CNT`: per-requester read-data strobe.
- `s_readdata` out `DATA_W`: read data, broadcast to all requesters.
- `m_address`, `m_read`, `m_write`, `m_byteenable`, `m_burstcount`, `m_writedata` out: granted command to memory.
- `m_waitrequest`, `m_readdatavalid` in 1; `m_readdata` in `DATA_W`: memory responses.

## Operation
- FSM states:
  - `IDLE`: no grant; all `s_waitrequest`=1; `m_read`/`m_write`=0. A requester is eligible if it asserts write, or asserts read while the owner FIFO is not full. Pick the first eligible requester strictly after `last_grant`, wrapping modulo `MASTERS_CNT`. Register `grant` and `last_grant`, then go to `CMD`.
  - `CMD`: the granted requester's signals are passed combinationally to `m_*`, and `s_waitrequest[grant]` = `m_waitrequest`.
    - Read accepted (`m_read & !m_waitrequest`): push {grant, burstcount} into the owner FIFO, go to `IDLE`.
    - Write beat accepted with burstcount 1: go to `IDLE`.
    - Write beat accepted with burstcount > 1: load `beats_left` = burstcount−1, go to `WR_BURST`.
  - `WR_BURST`: grant is held. `s_write[grant]` may drop between beats; such idle cycles are legal. Each accepted beat decrements `beats_left`; when the last beat is accepted, go to `IDLE`. Only the first beat's burstcount is sampled.
- burstcount 0 is treated as 1.
- Read return path:
  - Owner FIFO head gives `rd_id` and `rd_len`. A beat counter counts `m_readdatavalid` beats.
  - `s_readdatavalid[rd_id]` = `m_readdatavalid`; all other `s_readdatavalid` = 0. `s_readdata` = `m_readdata`.
  - Pop the FIFO and clear the counter on beat `rd_len`.
  - A push and a pop in the same cycle are both performed.
- `m_readdatavalid` with the FIFO empty is a protocol error: ignored, and flagged by a simulation-only assertion.

## Timing
- Reset values: state `IDLE`; `last_grant` = `MASTERS_CNT-1`, so requester 0 wins first; FIFO empty; beat counter 0; all `s_waitrequest`=1; all `s_readdatavalid`=0; `m_read`=`m_write`=0.
- Command latency: a request sampled in `IDLE` at cycle N appears on `m_*` at N+1.
  - Minimum per-command occupancy is 2 cycles: one `IDLE` bubble between consecutive grants.
- Read data has zero added latency: `m_*` to `s_*` is combinational.
- Owner FIFO full: read requests are not eligible. A write from another requester may still be granted; the read requester sees waitrequest=1.
- Reset mid-burst or with reads outstanding: all state is discarded. Late `m_readdatavalid` after reset is ignored because the FIFO is empty.

## Structure
- Package `amm_arb_pkg`:
  - `arb_state_t` enum (`IDLE`, `CMD`, `WR_BURST`).
  - Function `id_w(MASTERS_CNT)` = `$clog2` with a minimum of 1.
  - Owner-entry struct typedef {id, len}.
- Sub-module `rd_owner_fifo`: single-clock, show-ahead FIFO with `RD_FIFO_DEPTH` entries of `id_w+BURST_W` bits, providing full, empty and simultaneous push/pop.

## Test plan
- Round-robin fairness: both requesters issue continuous single writes -> grants alternate 0,1,0,1; `m_write` cycles spaced 2 apart.
- Write-burst lock: requester 0 issues a burst of 4 with a 1-cycle gap after beat 2; requester 1 requests a read at beat 1 -> requester 1 is not granted until all 4 beats are accepted.
- Read routing: requester 0 reads burst 3, requester 1 reads burst 2; memory returns 5 beats back-to-back -> `s_readdatavalid[0]` pulses for 3 cycles then `s_readdatavalid[1]` for 2; FIFO empty after.
- FIFO full: 8 outstanding single reads with no data returned -> a 9th read is held with waitrequest=1; one returned beat -> it is granted on the next `IDLE`.
- Backpressure: `m_waitrequest`=1 for 5 cycles during `CMD` -> granted requester's waitrequest=1 for those 5 cycles; command stable on `m_*`.
- Reset mid-burst: reset asserted at beat 2 of an 8-beat write -> next cycle `m_write`=0, all `s_waitrequest`=1; requester 0 is granted first afterwards.
